// File: rtl/cam_trans_driver.sv
`default_nettype none
// ============================================================================
// Module      : cam_trans_driver
// Description : Queues CAM commands in a small FIFO and runs them one at a
//               time through a WRITE / READ / RESET sequence. Each completed
//               command produces a response record stamped with a logical
//               time. READ hits and misses are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_trans_driver #(
    parameter int KEY_W      = 16,
    parameter int VAL_W      = 16,
    parameter int FIFO_DEPTH = 4,   // power of two, at least 2
    parameter int RST_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // command side
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_type_i,
    input  logic [KEY_W-1:0] cmd_key_i,
    input  logic [VAL_W-1:0] cmd_wdata_i,
    // CAM side
    output logic             cam_write_o,
    output logic             cam_read_o,
    output logic             cam_rst_o,
    output logic [KEY_W-1:0] cam_key_o,
    output logic [VAL_W-1:0] cam_wdata_o,
    input  logic [VAL_W-1:0] cam_rdata_i,
    input  logic             cam_valid_i,
    // response side
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_type_o,
    output logic [KEY_W-1:0] rsp_key_o,
    output logic [VAL_W-1:0] rsp_wdata_o,
    output logic [VAL_W-1:0] rsp_rdata_o,
    output logic             rsp_hit_o,
    output logic [31:0]      rsp_ltime_o,
    output logic [15:0]      hit_cnt_o,
    output logic [15:0]      miss_cnt_o
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] c_CMD_NONE  = 2'd0;
    localparam logic [1:0] c_CMD_WRITE = 2'd1;
    localparam logic [1:0] c_CMD_READ  = 2'd2;
    localparam logic [1:0] c_CMD_RESET = 2'd3;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_ISSUE   = 3'd1;
    localparam logic [2:0] c_S_CAPTURE = 3'd2;
    localparam logic [2:0] c_S_RSTHOLD = 3'd3;
    localparam logic [2:0] c_S_RESP    = 3'd4;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [1:0]         r_fifo_type  [FIFO_DEPTH];
    logic [KEY_W-1:0]   r_fifo_key   [FIFO_DEPTH];
    logic [VAL_W-1:0]   r_fifo_wdata [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [2:0]         r_state;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_head_type;
    logic [KEY_W-1:0]   w_head_key;
    logic [VAL_W-1:0]   w_head_wdata;

    assign w_full       = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    // Ready depends only on occupancy, so a full FIFO never takes a push even
    // when the head is popped in the same cycle.
    assign w_push       = cmd_valid_i && !w_full;
    // Every head entry, NONE included, leaves the FIFO from IDLE.
    assign w_pop        = (r_state == c_S_IDLE) && !w_empty;
    assign w_head_type  = r_fifo_type[r_rd_ptr];
    assign w_head_key   = r_fifo_key[r_rd_ptr];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr];
    assign cmd_ready_o  = !w_full;

    // FIFO storage; contents need no reset since occupancy guards them
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_type[r_wr_ptr]  <= cmd_type_i;
            r_fifo_key[r_wr_ptr]   <= cmd_key_i;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Transaction sequencer
    // ------------------------------------------------------------------------
    logic [1:0]       r_type;
    logic [KEY_W-1:0] r_key;
    logic [VAL_W-1:0] r_wdata;
    logic [VAL_W-1:0] r_rdata;
    logic             r_hit;
    logic [31:0]      r_ltime;
    logic [31:0]      r_rsp_ltime;
    logic [31:0]      r_rst_left;
    logic [15:0]      r_hit_cnt;
    logic [15:0]      r_miss_cnt;
    logic             r_cam_write;
    logic             r_cam_read;
    logic             r_cam_rst;
    logic             r_rsp_valid;

    // Sequencer: strobes are set on entry to ISSUE so they are registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_S_IDLE;
            r_type      <= c_CMD_NONE;
            r_key       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_hit       <= 1'b0;
            r_ltime     <= '0;
            r_rsp_ltime <= '0;
            r_rst_left  <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_cam_write <= 1'b0;
            r_cam_read  <= 1'b0;
            r_cam_rst   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (!w_empty && (w_head_type != c_CMD_NONE)) begin
                        r_type      <= w_head_type;
                        r_key       <= w_head_key;
                        r_wdata     <= w_head_wdata;
                        r_rdata     <= '0;
                        r_hit       <= 1'b0;
                        r_cam_write <= (w_head_type == c_CMD_WRITE);
                        r_cam_read  <= (w_head_type == c_CMD_READ);
                        r_cam_rst   <= (w_head_type == c_CMD_RESET);
                        r_state     <= c_S_ISSUE;
                    end
                end
                c_S_ISSUE: begin
                    r_rsp_ltime <= r_ltime;
                    r_ltime     <= r_ltime + 32'd1;
                    r_cam_write <= 1'b0;
                    r_cam_read  <= 1'b0;
                    case (r_type)
                        c_CMD_READ: r_state <= c_S_CAPTURE;
                        c_CMD_RESET: begin
                            // The ISSUE cycle is the first cycle of the pulse.
                            if (RST_CYCLES > 1) begin
                                r_rst_left <= 32'(RST_CYCLES - 2);
                                r_state    <= c_S_RSTHOLD;
                            end else begin
                                r_cam_rst   <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= c_S_RESP;
                            end
                        end
                        default: begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= c_S_RESP;
                        end
                    endcase
                end
                c_S_CAPTURE: begin
                    r_rdata <= cam_rdata_i;
                    r_hit   <= cam_valid_i;
                    if (cam_valid_i) begin
                        if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
                    end else begin
                        if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_S_RESP;
                end
                c_S_RSTHOLD: begin
                    if (r_rst_left == 32'd0) begin
                        r_cam_rst   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_S_RESP;
                    end else begin
                        r_rst_left <= r_rst_left - 32'd1;
                    end
                end
                c_S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: begin
                    r_cam_write <= 1'b0;
                    r_cam_read  <= 1'b0;
                    r_cam_rst   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= c_S_IDLE;
                end
            endcase
        end
    end

    assign cam_write_o = r_cam_write;
    assign cam_read_o  = r_cam_read;
    assign cam_rst_o   = r_cam_rst;
    assign cam_key_o   = r_key;
    assign cam_wdata_o = r_wdata;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_type_o  = r_type;
    assign rsp_key_o   = r_key;
    assign rsp_wdata_o = r_wdata;
    assign rsp_rdata_o = r_rdata;
    assign rsp_hit_o   = r_hit;
    assign rsp_ltime_o = r_rsp_ltime;
    assign hit_cnt_o   = r_hit_cnt;
    assign miss_cnt_o  = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cam_trans_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_trans_driver
// Description : Self-checking bench for cam_trans_driver with a behavioural
//               CAM device, a command-level reference model, directed
//               vectors, corner sequences and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_trans_driver;

    localparam int KEY_W      = 16;
    localparam int VAL_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int RST_CYCLES = 2;
    localparam int c_LIMIT    = 200;
    localparam logic [15:0] c_MISS_XOR = 16'h5A5A;

    logic             clk_i;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_type_i;
    logic [KEY_W-1:0] cmd_key_i;
    logic [VAL_W-1:0] cmd_wdata_i;
    logic             cam_write_o;
    logic             cam_read_o;
    logic             cam_rst_o;
    logic [KEY_W-1:0] cam_key_o;
    logic [VAL_W-1:0] cam_wdata_o;
    logic [VAL_W-1:0] cam_rdata_i;
    logic             cam_valid_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [1:0]       rsp_type_o;
    logic [KEY_W-1:0] rsp_key_o;
    logic [VAL_W-1:0] rsp_wdata_o;
    logic [VAL_W-1:0] rsp_rdata_o;
    logic             rsp_hit_o;
    logic [31:0]      rsp_ltime_o;
    logic [15:0]      hit_cnt_o;
    logic [15:0]      miss_cnt_o;

    cam_trans_driver #(
        .KEY_W(KEY_W), .VAL_W(VAL_W), .FIFO_DEPTH(FIFO_DEPTH), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_type_i(cmd_type_i),
        .cmd_key_i(cmd_key_i), .cmd_wdata_i(cmd_wdata_i),
        .cam_write_o(cam_write_o), .cam_read_o(cam_read_o), .cam_rst_o(cam_rst_o),
        .cam_key_o(cam_key_o), .cam_wdata_o(cam_wdata_o),
        .cam_rdata_i(cam_rdata_i), .cam_valid_i(cam_valid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_type_o(rsp_type_o),
        .rsp_key_o(rsp_key_o), .rsp_wdata_o(rsp_wdata_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_hit_o(rsp_hit_o), .rsp_ltime_o(rsp_ltime_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  typ;
        logic [15:0] key;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        hit;
        logic [31:0] ltime;
    } rec_t;

    typedef struct {
        logic [1:0]  typ;
        logic [15:0] key;
        logic [15:0] wdata;
        logic [15:0] e_rdata;
        logic        e_hit;
        logic [31:0] e_ltime;
        logic [15:0] e_hits;
        logic [15:0] e_miss;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [1:0]  t;
        logic [15:0] k;
        logic [15:0] d;
    } cmd_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural CAM device driven by the DUT strobes -------
    logic [15:0] dev_mem [int];
    bit          rd_pend;
    logic [15:0] rd_key;

    always @(negedge clk_i) begin
        rd_pend = !rst_i && cam_read_o;
        rd_key  = cam_key_o;
        if (!rst_i && cam_write_o) dev_mem[int'(cam_key_o)] = cam_wdata_o;
        if (!rst_i && cam_rst_o) dev_mem.delete();
    end

    always @(posedge clk_i) begin
        #1;
        if (rd_pend) begin
            if (dev_mem.exists(int'(rd_key))) begin
                cam_valid_i = 1'b1;
                cam_rdata_i = dev_mem[int'(rd_key)];
            end else begin
                cam_valid_i = 1'b0;
                cam_rdata_i = rd_key ^ c_MISS_XOR;
            end
        end else begin
            cam_rdata_i = 16'($urandom);
            cam_valid_i = 1'($urandom);
        end
    end

    // ---------------- strobe monitor: exclusivity and pulse lengths ----------
    int run_w = 0;
    int run_r = 0;
    int run_c = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("strobes_in_reset", {29'd0, cam_write_o, cam_read_o, cam_rst_o}, 32'd0);
            run_w = 0; run_r = 0; run_c = 0;
        end else begin
            if (cam_write_o || cam_read_o || cam_rst_o)
                chk("strobe_onehot", 32'(cam_write_o) + 32'(cam_read_o) + 32'(cam_rst_o), 32'd1);
            if (cam_write_o) run_w++;
            else if (run_w != 0) begin chk("write_pulse_len", 32'(run_w), 32'd1); run_w = 0; end
            if (cam_read_o) run_r++;
            else if (run_r != 0) begin chk("read_pulse_len", 32'(run_r), 32'd1); run_r = 0; end
            if (cam_rst_o) run_c++;
            else if (run_c != 0) begin chk("rst_pulse_len", 32'(run_c), 32'(RST_CYCLES)); run_c = 0; end
        end
    end

    // ---------------- command-level reference model --------------------------
    logic [31:0] ref_ltime = 32'd0;
    logic [15:0] ref_hits  = 16'd0;
    logic [15:0] ref_miss  = 16'd0;
    logic [15:0] ref_mem [int];
    rec_t        exp_q [$];

    task automatic ref_apply(input logic [1:0] t, input logic [15:0] k, input logic [15:0] d);
        rec_t e;
        if (t == 2'd0) return;
        e.typ = t; e.key = k; e.wdata = d; e.rdata = 16'd0; e.hit = 1'b0;
        e.ltime = ref_ltime;
        ref_ltime = ref_ltime + 32'd1;
        if (t == 2'd1) ref_mem[int'(k)] = d;
        if (t == 2'd2) begin
            e.hit   = ref_mem.exists(int'(k)) ? 1'b1 : 1'b0;
            e.rdata = e.hit ? ref_mem[int'(k)] : (k ^ c_MISS_XOR);
            if (e.hit) begin if (ref_hits != 16'hFFFF) ref_hits = ref_hits + 16'd1; end
            else begin if (ref_miss != 16'hFFFF) ref_miss = ref_miss + 16'd1; end
        end
        if (t == 2'd3) ref_mem.delete();
        exp_q.push_back(e);
    endtask

    task automatic ref_clear_run();
        ref_ltime = 32'd0; ref_hits = 16'd0; ref_miss = 16'd0;
        exp_q.delete();
    endtask

    // ---------------- driver / receiver (called at a falling edge) -----------
    task automatic send(input logic [1:0] t, input logic [15:0] k, input logic [15:0] d,
                        output int waits);
        waits = 0;
        cmd_valid_i = 1'b1; cmd_type_i = t; cmd_key_i = k; cmd_wdata_i = d;
        while (!cmd_ready_o && waits < c_LIMIT) begin @(negedge clk_i); waits++; end
        if (!cmd_ready_o) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout: ready low for %0d cycles, required high", waits);
        end else begin
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic expect_rec(input rec_t e, input string tag, input int hold, output int lat);
        rsp_ready_i = 1'b0;
        lat = 0;
        while (!rsp_valid_o && lat < c_LIMIT) begin @(negedge clk_i); lat++; end
        if (!rsp_valid_o) begin
            checks++; failures++;
            $display("FAIL %s_timeout: rsp_valid 0 after %0d cycles, required 1", tag, lat);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
        end
        chk({tag, "_type"},  32'(rsp_type_o),  32'(e.typ));
        chk({tag, "_key"},   32'(rsp_key_o),   32'(e.key));
        chk({tag, "_wdata"}, 32'(rsp_wdata_o), 32'(e.wdata));
        chk({tag, "_rdata"}, 32'(rsp_rdata_o), 32'(e.rdata));
        chk({tag, "_hit"},   32'(rsp_hit_o),   32'(e.hit));
        chk({tag, "_ltime"}, rsp_ltime_o,      e.ltime);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk({tag, "_drop"}, 32'(rsp_valid_o), 32'd0);
    endtask

    task automatic no_record(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin @(negedge clk_i); if (rsp_valid_o) seen++; end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ------------------------------------------
    initial begin
        vec_t tbl [7];
        rec_t e;
        cmd_t cl [$];
        int   lat, w, stalls, n, r;

        tbl[0] = '{2'd1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0, 32'd0, 16'd0, 16'd0, 2};
        tbl[1] = '{2'd2, 16'h0012, 16'h0000, 16'hBEEF, 1'b1, 32'd1, 16'd1, 16'd0, 3};
        tbl[2] = '{2'd2, 16'h0034, 16'h0000, 16'h5A6E, 1'b0, 32'd2, 16'd1, 16'd1, 3};
        tbl[3] = '{2'd1, 16'h0034, 16'h1234, 16'h0000, 1'b0, 32'd3, 16'd1, 16'd1, 2};
        tbl[4] = '{2'd2, 16'h0034, 16'h0000, 16'h1234, 1'b1, 32'd4, 16'd2, 16'd1, 3};
        tbl[5] = '{2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 32'd5, 16'd2, 16'd1, 3};
        tbl[6] = '{2'd2, 16'h0012, 16'h0000, 16'h5A48, 1'b0, 32'd6, 16'd2, 16'd2, 3};

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_type_i = 2'd0; cmd_key_i = 16'd0;
        cmd_wdata_i = 16'd0; rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_strobes", {29'd0, cam_write_o, cam_read_o, cam_rst_o}, 32'd0);
        chk("reset_hit_cnt", 32'(hit_cnt_o), 32'd0);
        chk("reset_miss_cnt", 32'(miss_cnt_o), 32'd0);

        // Directed vectors, one transaction in flight at a time
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].typ, tbl[i].key, tbl[i].wdata, w);
            ref_apply(tbl[i].typ, tbl[i].key, tbl[i].wdata);
            void'(exp_q.pop_front());
            e = '{tbl[i].typ, tbl[i].key, tbl[i].wdata, tbl[i].e_rdata, tbl[i].e_hit, tbl[i].e_ltime};
            expect_rec(e, $sformatf("vec%0d", i), 0, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].e_lat));
            chk($sformatf("vec%0d_hit_cnt", i), 32'(hit_cnt_o), 32'(tbl[i].e_hits));
            chk($sformatf("vec%0d_miss_cnt", i), 32'(miss_cnt_o), 32'(tbl[i].e_miss));
        end

        // NONE is discarded; the following READ takes the next logical time
        send(2'd0, 16'h0055, 16'h1111, w); ref_apply(2'd0, 16'h0055, 16'h1111);
        send(2'd2, 16'h0012, 16'h0000, w); ref_apply(2'd2, 16'h0012, 16'h0000);
        e = exp_q.pop_front();
        expect_rec(e, "none_read", 0, lat);
        chk("none_read_ltime", rsp_ltime_o, 32'd7);
        no_record("none_no_record", 8);

        // Back-pressure: one in flight plus a full FIFO, then drain in order
        cl.delete();
        cl.push_back('{2'd1, 16'h0001, 16'hA001});
        cl.push_back('{2'd2, 16'h0001, 16'h0000});
        cl.push_back('{2'd1, 16'h0002, 16'hA002});
        cl.push_back('{2'd2, 16'h0003, 16'h0000});
        cl.push_back('{2'd2, 16'h0002, 16'h0000});
        cl.push_back('{2'd1, 16'h0004, 16'hA004});
        foreach (cl[i]) ref_apply(cl[i].t, cl[i].k, cl[i].d);
        stalls = 0;
        for (int i = 0; i < 5; i++) begin send(cl[i].t, cl[i].k, cl[i].d, w); stalls += w; end
        chk("bp_no_stall", 32'(stalls), 32'd0);
        chk("bp_ready_low", 32'(cmd_ready_o), 32'd0);
        n = 0;
        repeat (4) begin @(negedge clk_i); if (cmd_ready_o) n++; end
        chk("bp_ready_stays_low", 32'(n), 32'd0);
        fork
            begin send(cl[5].t, cl[5].k, cl[5].d, w); end
            begin
                rec_t eb;
                int   lb;
                for (int i = 0; i < 6; i++) begin
                    eb = exp_q.pop_front();
                    expect_rec(eb, $sformatf("bp%0d", i), 0, lb);
                end
            end
        join

        // Randomized traffic with random gaps and random response stalls
        cl.delete();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            cl.push_back('{(r == 0) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                           16'($urandom_range(0, 7)), 16'($urandom)});
        end
        foreach (cl[i]) ref_apply(cl[i].t, cl[i].k, cl[i].d);
        n = exp_q.size();
        fork
            begin
                int wr;
                foreach (cl[i]) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk_i);
                    send(cl[i].t, cl[i].k, cl[i].d, wr);
                end
            end
            begin
                rec_t er;
                int   lr;
                for (int i = 0; i < n; i++) begin
                    er = exp_q.pop_front();
                    expect_rec(er, $sformatf("rnd%0d", i), $urandom_range(0, 2), lr);
                end
            end
        join
        chk("rnd_hit_cnt", 32'(hit_cnt_o), 32'(ref_hits));
        chk("rnd_miss_cnt", 32'(miss_cnt_o), 32'(ref_miss));

        // Reset during CAPTURE: no record, counters cleared at once
        send(2'd2, 16'h0001, 16'h0000, w);
        n = 0;
        while (!cam_read_o && n < c_LIMIT) begin @(negedge clk_i); n++; end
        chk("abort_rd_seen_read", 32'(cam_read_o), 32'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("abort_rd_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort_rd_strobes", {29'd0, cam_write_o, cam_read_o, cam_rst_o}, 32'd0);
        chk("abort_rd_hit_cnt", 32'(hit_cnt_o), 32'd0);
        chk("abort_rd_miss_cnt", 32'(miss_cnt_o), 32'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        ref_clear_run();
        @(negedge clk_i);
        chk("abort_rd_cmd_ready", 32'(cmd_ready_o), 32'd1);
        no_record("abort_rd_no_record", 10);

        // Reset during the CAM reset pulse cuts the pulse immediately
        send(2'd3, 16'h0000, 16'h0000, w);
        n = 0;
        while (!cam_rst_o && n < c_LIMIT) begin @(negedge clk_i); n++; end
        chk("abort_rst_seen_pulse", 32'(cam_rst_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("abort_rst_strobe", 32'(cam_rst_o), 32'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        ref_mem.delete();
        ref_clear_run();
        no_record("abort_rst_no_record", 10);

        // Clean restart: logical time starts again from zero
        send(2'd1, 16'h0077, 16'h55AA, w); ref_apply(2'd1, 16'h0077, 16'h55AA);
        send(2'd2, 16'h0077, 16'h0000, w); ref_apply(2'd2, 16'h0077, 16'h0000);
        e = exp_q.pop_front(); expect_rec(e, "post_wr", 0, lat);
        e = exp_q.pop_front(); expect_rec(e, "post_rd", 0, lat);
        chk("post_hit_cnt", 32'(hit_cnt_o), 32'(ref_hits));
        chk("post_miss_cnt", 32'(miss_cnt_o), 32'(ref_miss));

        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_trans_driver.md
CAM_TRANS_DRIVER -- requirements
Module: cam_trans_driver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- KEY_W, 16, key width
- VAL_W, 16, value width
- FIFO_DEPTH, 4, command FIFO entries (power of 2)
- RST_CYCLES, 2, CAM reset pulse length
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk_i in 1 single clock, all logic on rising edge
- rst_i in 1 asynchronous, active-high reset
- cmd_valid_i in 1 command offered
- cmd_ready_o out 1 command accepted when high with cmd_valid_i
- cmd_type_i in 2 0=NONE 1=WRITE 2=READ 3=RESET
- cmd_key_i in KEY_W transaction key
- cmd_wdata_i in VAL_W write data
- cam_write_o out 1 CAM write strobe
- cam_read_o out 1 CAM read strobe
- cam_rst_o out 1 CAM synchronous reset request
- cam_key_o out KEY_W CAM key
- cam_wdata_o out VAL_W CAM write data
- cam_rdata_i in VAL_W CAM read data, valid 1 cycle after cam_read_o
- cam_valid_i in 1 CAM hit flag, same timing as cam_rdata_i
- rsp_valid_o out 1 completed transaction record available
- rsp_ready_i in 1 downstream accepts record
- rsp_type_o out 2 transaction type
- rsp_key_o, rsp_wdata_o, rsp_rdata_o out KEY_W/VAL_W/VAL_W record fields
- rsp_hit_o out 1 captured cam_valid_i (READ only, else 0)
- rsp_ltime_o out 32 logical time of transaction
- hit_cnt_o, miss_cnt_o out 16 READ hit/miss counters

Function
REQ-003 Commands SHALL enter a FIFO_DEPTH-entry FIFO; cmd_ready_o = not full; push on cmd_valid_i && cmd_ready_o.
REQ-004 Simultaneous push and pop on a full FIFO SHALL NOT be accepted (ready is low when full); simultaneous push/pop when non-full SHALL keep occupancy unchanged.
REQ-005 Control SHALL be an FSM: IDLE, ISSUE, CAPTURE, RSTHOLD, RESP.
REQ-006 IDLE: FIFO non-empty -> pop head into a transaction register, go ISSUE; NONE entries SHALL be popped and discarded in IDLE (no strobe, no record, ltime unchanged), one per cycle.
REQ-007 ISSUE (exactly one cycle): drive cam_key_o/cam_wdata_o from the register; WRITE asserts cam_write_o -> RESP; READ asserts cam_read_o -> CAPTURE; RESET asserts cam_rst_o -> RSTHOLD.
REQ-008 Strobes SHALL be mutually exclusive and high for exactly one cycle, except cam_rst_o (REQ-010).
REQ-009 CAPTURE: register cam_rdata_i and cam_valid_i; increment hit_cnt_o if cam_valid_i else miss_cnt_o; -> RESP.
REQ-010 RSTHOLD: cam_rst_o SHALL stay high so total pulse = RST_CYCLES cycles, then -> RESP; hit/miss counters are NOT cleared by a RESET transaction.
REQ-011 rsp_ltime_o SHALL equal a 32-bit counter value sampled in ISSUE; counter increments by 1 per issued non-NONE transaction, wraps 0xFFFFFFFF -> 0.
REQ-012 RESP: rsp_valid_o high, fields stable until rsp_ready_i; on handshake -> IDLE; rsp_rdata_o = 0 for WRITE/RESET.
REQ-013 Counters SHALL saturate at 0xFFFF.
REQ-014 Min throughput: READ 4 cycles, WRITE 3 cycles, RESET RST_CYCLES+2 cycles per transaction with rsp_ready_i held high.

Reset
REQ-015 rst_i SHALL asynchronously clear: FIFO empty, FSM IDLE, ltime 0, counters 0, all strobes 0, rsp_valid_o 0, cmd_ready_o 1 after release.
REQ-016 rst_i mid-transaction SHALL abort it with no record and deassert strobes immediately (including an in-progress cam_rst_o pulse).

Verification
REQ-017 WRITE key=0x0012 wdata=0xBEEF -> one cycle cam_write_o with key/wdata, record {WRITE,0x0012,0xBEEF,rdata 0,hit 0,ltime 0}.
REQ-018 READ key=0x0012, CAM returns 0xBEEF/valid=1 -> record rdata=0xBEEF hit=1 ltime=1, hit_cnt_o=1.
REQ-019 5 commands offered back-to-back with rsp_ready_i=0 -> cmd_ready_o low after 4 pushes beyond the one in flight; no loss or reordering after rsp_ready_i=1.
REQ-020 RESET command, RST_CYCLES=2 -> cam_rst_o high exactly 2 cycles, then one RESET record; counters unchanged.
REQ-021 NONE, READ queued -> no record for NONE; READ record ltime equals prior ltime+1.
REQ-022 rst_i asserted during CAPTURE -> rsp_valid_o never asserts, counters 0, strobes low in the same cycle.
